nanci_responder: RTL

Node-side responder for the Nanci request/result interface. It accepts request words from the network in the `{op, addr, data}` format that application modules issue, and buffers them in a small FIFO. Each request is serviced in order against a small local word store, and a result word is returned in the `nanci_result` format with bit WIDTH as the valid flag. It sits between the network egress port of a node and that node's local storage.

---
 rtl/nanci_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/nanci_responder.sv
// Nanci node-side responder: buffers {op, addr, data} requests in a FIFO and
// services them in order against a local word store, returning one result each.
module nanci_responder #(
   parameter int N              = 1024,
   parameter int I              = 0,
   parameter int DATA_WIDTH     = 10,
   parameter int ADDR_WIDTH     = 10,
   parameter int LOCAL_AW       = 4,
   parameter int SERVICE_CYCLES = 2,
   parameter int FIFO_DEPTH     = 4,
   localparam int WIDTH         = ADDR_WIDTH + DATA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic [WIDTH:0]   request,
   output logic             req_ready,
   output logic [WIDTH:0]   nanci_result,
   input  logic             result_ready,
   output logic [13:0]      served_count
);

   localparam int PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW      = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;
   localparam int STORE_N = 1 << LOCAL_AW;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, SERVICE, RESPOND} state_t;

   state_t                 state;
   logic [WIDTH:0]         fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [PW:0]            count;
   logic [WIDTH:0]         req_q;
   logic [CW-1:0]          cnt;
   logic [DATA_WIDTH-1:0]  store [STORE_N];
   logic [STORE_N-1:0]     written;
   logic                   push;
   logic                   pop;
   logic                   commit;
   logic                   req_op;
   logic [ADDR_WIDTH-1:0]  req_addr;
   logic [DATA_WIDTH-1:0]  req_data;
   logic [LOCAL_AW-1:0]    idx;
   logic                   unused_cfg;

   // Handshakes: a word transfers on an edge where its valid and ready are both high;
   // nanci_result[WIDTH] is the valid of the result side and holds until result_ready.
   assign req_ready = (count != FULL_CNT);
   assign push      = req_valid && req_ready;
   assign pop       = (state == IDLE) && (count != '0);
   assign commit    = (state == SERVICE) && (cnt == '0);

   assign req_op     = req_q[WIDTH];
   assign req_addr   = req_q[WIDTH-1:DATA_WIDTH];
   assign req_data   = req_q[DATA_WIDTH-1:0];
   assign idx        = req_q[DATA_WIDTH +: LOCAL_AW];
   assign unused_cfg = (N > I);

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= request;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Store words are never reset; the written bitmap masks stale contents to zero.
   always_ff @(posedge clk) begin
      if (commit && req_op) store[idx] <= req_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         req_q        <= '0;
         cnt          <= '0;
         nanci_result <= '0;
         served_count <= '0;
         written      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  req_q <= fifo_mem[rd_ptr];
                  cnt   <= CW'(SERVICE_CYCLES - 1);
                  state <= SERVICE;
               end
            end
            SERVICE: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  if (req_op) begin
                     written[idx] <= 1'b1;
                     nanci_result <= {1'b1, req_addr, req_data};
                  end else begin
                     nanci_result <= {1'b1, req_addr,
                                      written[idx] ? store[idx] : {DATA_WIDTH{1'b0}}};
                  end
                  state <= RESPOND;
               end
            end
            RESPOND: begin
               if (result_ready) begin
                  nanci_result[WIDTH] <= 1'b0;
                  if (served_count != '1) served_count <= served_count + 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
